dec_ins: RTL and testbench
==========================

Name: dec_ins

Overview:
- Decode/operand-fetch stage of the multi-cycle MIPS core. Sits directly downstream of the instruction-fetch stage and consumes the fetched `ir_reg`.
- On the decode timer phase it latches the instruction, splits the fields and sign/zero-extends the immediate.
- It then reads rs and rt from the shared single-port register file and presents A/B operands to the execute stage with a done pulse.

Parameters:
WORD_SIZE, 32, datapath/instruction width
TIMER_SIZE, 3, width of timer phase bus
CYC_DECODE, 3'd2, timer value that starts decode (CYCLE2)

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous active-high reset
timer  input  TIMER_SIZE  current machine-cycle phase
ir_reg  input  WORD_SIZE  instruction from fetch stage
reg_data_out  input  WORD_SIZE  register-file read data, 1-clock latency
reg_on  output  1  register-file access enable
reg_w  output  1  register-file write enable, tied 0
reg_addr  output  WORD_SIZE  register-file address, 5-bit field zero-extended
opcode  output  6  ir[31:26]
rs, rt, rd  output  5 each  ir[25:21], ir[20:16], ir[15:11]
shamt  output  5  ir[10:6]
funct  output  6  ir[5:0]
imm_ext  output  WORD_SIZE  extended immediate
jtarget  output  26  ir[25:0]
a_reg, b_reg  output  WORD_SIZE  operands for rs/rt
busy  output  1  decode in progress
dec_done  output  1  one-clock completion pulse
illegal_op  output  1  unsupported opcode (optional feature)

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; internal ir_q 0; timer-previous register 0.
- Start: the cycle where timer==CYC_DECODE and the registered previous timer != CYC_DECODE (rising into phase), in state IDLE.
  - Start is ignored while busy.
  - A timer change during an operation does not abort it.
- FSM states: IDLE, RS, RT, CAP, DONE.
  - IDLE: on start, ir_q <= ir_reg; go to RS.
  - RS: reg_on=1, reg_addr=rs; go to RT.
  - RT: reg_on=1, reg_addr=rt; a_reg <= reg_data_out, or 0 if rs==0; go to CAP.
  - CAP: reg_on=0; b_reg <= reg_data_out, or 0 if rt==0; go to DONE.
  - DONE: dec_done=1 for exactly one clock; go to IDLE.
- Timing: dec_done is high in the 4th clock after the start edge. busy is high in RS, RT, CAP and DONE.
- Outside RS/RT: reg_on=0 and reg_addr=0. reg_w is always 0.
- Field outputs decode combinationally from ir_q. They are stable from the clock after start until the next start.
- imm_ext:
  - zero-extend ir[15:0] for opcodes 0x0C/0x0D/0x0E (andi/ori/xori);
  - ir[15:0]<<16 for 0x0F (lui);
  - otherwise sign-extend bit 15.
- a_reg and b_reg hold their values until the next capture.
- Reset mid-operation returns the block to IDLE immediately, clears all outputs and emits no dec_done.

Optional Feature:
- Macro: DEC_ILLEGAL_CHK_EN.
- Legal opcode set: 0x00, 0x02, 0x03, 0x04, 0x05, 0x08–0x0F, 0x23, 0x2B.
- With the macro defined:
  - illegal_op is registered at start: 1 if opcode is outside the legal set, else 0.
  - It holds until the next start.
  - The register reads still occur.
- Without the macro: illegal_op is tied 0 and no check logic is built.

Test Plan:
- ir_reg=0x012A4020 (add $8,$9,$10), RF r9=0x11, r10=0x22, timer steps to 2 -> opcode 0, rs 9, rt 10, rd 8, funct 0x20; reg_addr 9 then 10; a_reg=0x11, b_reg=0x22; dec_done 1 clock at start+4.
- ir_reg=0x2128FFFF (addi) -> imm_ext=0xFFFFFFFF. ir_reg=0x3528FFFF (ori) -> imm_ext=0x0000FFFF. ir_reg=0x3C081234 (lui) -> imm_ext=0x12340000.
- ir_reg=0x00004020 with reg_data_out forced 0xDEADBEEF -> a_reg=0, b_reg=0.
- timer held at 2 for 10 clocks -> exactly one dec_done. Timer re-entering phase 2 while busy -> ignored.
- rst asserted in state RT -> outputs 0 asynchronously, no dec_done. Next phase-2 entry -> normal decode.
- With DEC_ILLEGAL_CHK_EN: ir_reg=0xFC000000 -> illegal_op=1; following 0x8D280004 (lw) -> illegal_op=0. Without the macro: illegal_op stays 0.

Source files
------------

// File: rtl/dec_ins_if.sv
// rtl/dec_ins_if.sv - register-file access bus between decode stage and shared register file
interface dec_ins_if #(
    parameter int WORD_SIZE = 32
) ();
    logic                 reg_on;
    logic                 reg_w;
    logic [WORD_SIZE-1:0] reg_addr;
    logic [WORD_SIZE-1:0] reg_data_out;

    modport master (
        output reg_on,
        output reg_w,
        output reg_addr,
        input  reg_data_out
    );

    modport slave (
        input  reg_on,
        input  reg_w,
        input  reg_addr,
        output reg_data_out
    );
endinterface

// File: rtl/dec_ins.sv
// rtl/dec_ins.sv - MIPS decode/operand-fetch stage; optional opcode check under DEC_ILLEGAL_CHK_EN
module dec_ins #(
    parameter int                    WORD_SIZE  = 32,
    parameter int                    TIMER_SIZE = 3,
    parameter logic [TIMER_SIZE-1:0] CYC_DECODE = 3'd2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [TIMER_SIZE-1:0] timer,
    input  logic [WORD_SIZE-1:0]  ir_reg,
    dec_ins_if.master             rf,
    output logic [5:0]            opcode,
    output logic [4:0]            rs,
    output logic [4:0]            rt,
    output logic [4:0]            rd,
    output logic [4:0]            shamt,
    output logic [5:0]            funct,
    output logic [WORD_SIZE-1:0]  imm_ext,
    output logic [25:0]           jtarget,
    output logic [WORD_SIZE-1:0]  a_reg,
    output logic [WORD_SIZE-1:0]  b_reg,
    output logic                  busy,
    output logic                  dec_done,
    output logic                  illegal_op
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RS   = 3'd1,
        RT   = 3'd2,
        CAP  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [WORD_SIZE-1:0]  ir_q, ir_d;
    logic [WORD_SIZE-1:0]  a_q, a_d;
    logic [WORD_SIZE-1:0]  b_q, b_d;
    logic [TIMER_SIZE-1:0] timer_prev_q;
    logic                  start;

    // Decode begins only on the cycle the timer rises into the decode phase
    assign start = (state_q == IDLE) && (timer == CYC_DECODE) && (timer_prev_q != CYC_DECODE);

    assign opcode  = ir_q[31:26];
    assign rs      = ir_q[25:21];
    assign rt      = ir_q[20:16];
    assign rd      = ir_q[15:11];
    assign shamt   = ir_q[10:6];
    assign funct   = ir_q[5:0];
    assign jtarget = ir_q[25:0];
    assign a_reg   = a_q;
    assign b_reg   = b_q;
    assign busy    = (state_q != IDLE);
    assign rf.reg_w = 1'b0;

    // Immediate extension: logical ops zero-extend, lui shifts up, everything else sign-extends
    always_comb begin
        imm_ext = {{(WORD_SIZE-16){ir_q[15]}}, ir_q[15:0]};
        case (ir_q[31:26])
            6'h0C, 6'h0D, 6'h0E: imm_ext = {{(WORD_SIZE-16){1'b0}}, ir_q[15:0]};
            6'h0F:               imm_ext = {ir_q[15:0], {(WORD_SIZE-16){1'b0}}};
            default:             imm_ext = {{(WORD_SIZE-16){ir_q[15]}}, ir_q[15:0]};
        endcase
    end

    // Next-state and register-file port control; read data arrives one clock after the address
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        rf.reg_on   = 1'b0;
        rf.reg_addr = '0;
        dec_done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ir_d    = ir_reg;
                    state_d = RS;
                end
            end
            RS: begin
                rf.reg_on   = 1'b1;
                rf.reg_addr = {{(WORD_SIZE-5){1'b0}}, rs};
                state_d     = RT;
            end
            RT: begin
                rf.reg_on   = 1'b1;
                rf.reg_addr = {{(WORD_SIZE-5){1'b0}}, rt};
                a_d         = (rs == 5'd0) ? '0 : rf.reg_data_out;
                state_d     = CAP;
            end
            CAP: begin
                b_d     = (rt == 5'd0) ? '0 : rf.reg_data_out;
                state_d = DONE;
            end
            DONE: begin
                dec_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, instruction, operand and timer-history registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ir_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            timer_prev_q <= '0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            a_q          <= a_d;
            b_q          <= b_d;
            timer_prev_q <= timer;
        end
    end

`ifdef DEC_ILLEGAL_CHK_EN
    logic illegal_q, illegal_d;
    logic op_legal;

    // Opcodes the core implements; anything else is flagged
    always_comb begin
        op_legal = 1'b0;
        case (ir_reg[31:26])
            6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
            6'h23, 6'h2B: op_legal = 1'b1;
            default:      op_legal = 1'b0;
        endcase
    end

    // Illegal flag is sampled with the instruction and held until the next decode
    always_comb begin
        illegal_d = illegal_q;
        if (start) illegal_d = ~op_legal;
    end

    // Illegal-opcode flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) illegal_q <= 1'b0;
        else     illegal_q <= illegal_d;
    end

    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_dec_ins.sv
// tb/tb_dec_ins.sv - self-checking bench for dec_ins with register-file model
module tb_dec_ins;

    typedef struct {
        logic [31:0] ir;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  timer;
    logic [31:0] ir_reg;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm_ext, a_reg, b_reg;
    logic [25:0] jtarget;
    logic        busy, dec_done, illegal_op;

    logic [31:0] rf [32];
    logic [31:0] rf_q = 32'd0;
    bit          force_en = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [5:0] legal_ops [15] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                                   6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};

    always #5 clk = ~clk;

    dec_ins_if #(.WORD_SIZE(32)) bus ();

    // Register file: synchronous read, one clock of latency
    always @(posedge clk) begin
        if (bus.reg_on && !bus.reg_w) rf_q <= rf[bus.reg_addr[4:0]];
    end
    assign bus.reg_data_out = force_en ? 32'hDEADBEEF : rf_q;

    dec_ins dut (
        .clk        (clk),
        .rst        (rst),
        .timer      (timer),
        .ir_reg     (ir_reg),
        .rf         (bus),
        .opcode     (opcode),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .shamt      (shamt),
        .funct      (funct),
        .imm_ext    (imm_ext),
        .jtarget    (jtarget),
        .a_reg      (a_reg),
        .b_reg      (b_reg),
        .busy       (busy),
        .dec_done   (dec_done),
        .illegal_op (illegal_op)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t ref_decode(input logic [31:0] ir);
        vec_t v;
        int unsigned w;
        int unsigned lo;
        w    = ir;
        lo   = w % 65536;
        v.ir = ir;
        v.op = 6'(w / 67108864);
        v.rs = 5'((w / 2097152) % 32);
        v.rt = 5'((w / 65536) % 32);
        v.rd = 5'((lo / 2048) % 32);
        v.sh = 5'((lo / 64) % 32);
        v.fn = 6'(lo % 64);
        if (v.op >= 6'h0C && v.op <= 6'h0E) v.imm = lo;
        else if (v.op == 6'h0F)             v.imm = lo * 65536;
        else if (lo >= 32768)               v.imm = lo + 32'hFFFF0000;
        else                                v.imm = lo;
        v.ill = 1'b1;
        foreach (legal_ops[i]) if (legal_ops[i] == v.op) v.ill = 1'b0;
        return v;
    endfunction

    task automatic run_decode(input vec_t v, input bit reenter, input bit scramble);
        logic [31:0] exp_a, exp_b;
        logic        exp_ill;
        int          dones;
        exp_a = (v.rs == 5'd0) ? 32'd0 : (force_en ? 32'hDEADBEEF : rf[v.rs]);
        exp_b = (v.rt == 5'd0) ? 32'd0 : (force_en ? 32'hDEADBEEF : rf[v.rt]);
`ifdef DEC_ILLEGAL_CHK_EN
        exp_ill = v.ill;
`else
        exp_ill = 1'b0;
`endif
        dones = 0;
        @(negedge clk);
        timer = 3'd1;
        @(negedge clk);
        ir_reg = v.ir;
        timer  = 3'd2;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            dones += int'(dec_done);
            if (k == 1) begin
                check("rs_phase_reg_on", bus.reg_on, 1);
                check("rs_phase_addr", bus.reg_addr, v.rs);
                check("reg_w", bus.reg_w, 0);
                check("busy_rs", busy, 1);
                if (scramble) ir_reg = $urandom;
                if (reenter)  timer = 3'd3;
            end
            if (k == 2) begin
                check("rt_phase_reg_on", bus.reg_on, 1);
                check("rt_phase_addr", bus.reg_addr, v.rt);
                if (reenter) timer = 3'd2;
            end
            if (k == 3) begin
                check("cap_reg_on", bus.reg_on, 0);
                check("cap_addr", bus.reg_addr, 0);
                check("cap_no_done", dec_done, 0);
                check("busy_cap", busy, 1);
            end
            if (k == 4) begin
                check("dec_done", dec_done, 1);
                check("opcode", opcode, v.op);
                check("rs", rs, v.rs);
                check("rt", rt, v.rt);
                check("rd", rd, v.rd);
                check("shamt", shamt, v.sh);
                check("funct", funct, v.fn);
                check("jtarget", jtarget, v.ir & 32'h03FFFFFF);
                check("imm_ext", imm_ext, v.imm);
                check("a_reg", a_reg, exp_a);
                check("b_reg", b_reg, exp_b);
                check("illegal_op", illegal_op, exp_ill);
            end
            if (k == 5) check("busy_idle", busy, 0);
            if (k == 10) begin
                check("a_hold", a_reg, exp_a);
                check("b_hold", b_reg, exp_b);
                check("opcode_hold", opcode, v.op);
            end
        end
        check("done_count", dones, 1);
        timer = 3'd1;
    endtask

    vec_t tbl [6];

    initial begin
        vec_t v;
        int   dones;
        tbl[0] = '{32'h012A4020, 6'h00, 5'd9, 5'd10, 5'd8,  5'd0,  6'h20, 32'h00004020, 1'b0};
        tbl[1] = '{32'h2128FFFF, 6'h08, 5'd9, 5'd8,  5'd31, 5'd31, 6'h3F, 32'hFFFFFFFF, 1'b0};
        tbl[2] = '{32'h3528FFFF, 6'h0D, 5'd9, 5'd8,  5'd31, 5'd31, 6'h3F, 32'h0000FFFF, 1'b0};
        tbl[3] = '{32'h3C081234, 6'h0F, 5'd0, 5'd8,  5'd2,  5'd8,  6'h34, 32'h12340000, 1'b0};
        tbl[4] = '{32'hFC000000, 6'h3F, 5'd0, 5'd0,  5'd0,  5'd0,  6'h00, 32'h00000000, 1'b1};
        tbl[5] = '{32'h8D280004, 6'h23, 5'd9, 5'd8,  5'd0,  5'd0,  6'h04, 32'h00000004, 1'b0};

        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0]  = 32'hBAD00000;
        rf[8]  = 32'h00000088;
        rf[9]  = 32'h00000011;
        rf[10] = 32'h00000022;

        rst    = 1'b1;
        timer  = 3'd0;
        ir_reg = 32'd0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", dec_done, 0);
        check("rst_reg_on", bus.reg_on, 0);
        check("rst_reg_addr", bus.reg_addr, 0);
        check("rst_a", a_reg, 0);
        check("rst_b", b_reg, 0);
        check("rst_imm", imm_ext, 0);
        check("rst_ill", illegal_op, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) run_decode(tbl[i], i == 1, i == 2);

        // Reset while in RT: everything clears at once and no completion is seen
        @(negedge clk);
        timer = 3'd1;
        @(negedge clk);
        ir_reg = 32'h012A4020;
        timer  = 3'd2;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_a", a_reg, 0);
        check("midrst_b", b_reg, 0);
        check("midrst_rd", rd, 0);
        check("midrst_reg_on", bus.reg_on, 0);
        check("midrst_reg_addr", bus.reg_addr, 0);
        dones = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            dones += int'(dec_done);
        end
        timer = 3'd1;
        rst   = 1'b0;
        check("midrst_no_done", dones, 0);
        run_decode(tbl[0], 1'b0, 1'b0);

        force_en = 1'b1;
        run_decode(ref_decode(32'h00004020), 1'b0, 1'b0);
        force_en = 1'b0;

        for (int n = 0; n < 40; n++) begin
            logic [31:0] w;
            for (int j = 0; j < 4; j++) rf[$urandom_range(0, 31)] = $urandom;
            w = $urandom;
            case ($urandom_range(0, 5))
                0: w[31:26] = 6'(6'h0C + $urandom_range(0, 3));
                1: w[31:26] = 6'h00;
                2: w[25:21] = 5'd0;
                3: w[20:16] = 5'd0;
                default: ;
            endcase
            v = ref_decode(w);
            run_decode(v, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
